// File: rtl/dmem_if.sv
// CPU-to-data-memory request/response bundle.
// The CPU drives requests and response-ready; the responder drives the rest.
interface dmem_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic [7:0]  err_count_o;

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o, err_count_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o, err_count_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data memory responder for the MEM stage.
// One access outstanding at a time; misaligned/out-of-range accesses are flagged.
module dmem_responder #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input logic   clk_i,
    input logic   rst_i,
    dmem_if.slave bus
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [7:0]  errcnt_q, errcnt_d;
    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];

    logic          acc_err;
    logic [IW-1:0] idx;

    assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH));
    assign idx     = addr_q[2 +: IW];

    assign bus.req_ready_o = (state_q == S_IDLE);
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;
    assign bus.err_count_o = errcnt_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        errcnt_d    = errcnt_q;
        mem_d       = mem_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    wr_d    = bus.req_write_i;
                    addr_d  = bus.req_addr_i;
                    wdata_d = bus.req_wdata_i;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rdata_d     = 32'd0;
                    err_d       = acc_err;
                    if (acc_err) begin
                        if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
                    end else if (wr_q) begin
                        mem_d[idx] = wdata_q;
                    end else begin
                        rdata_d = mem_q[idx];
                    end
                end
            end
            S_RESP: begin
                // Outputs hold until the CPU takes the response
                if (bus.rsp_ready_i) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            errcnt_q    <= 8'd0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            errcnt_q    <= errcnt_d;
            mem_q       <= mem_d;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: main instance at LATENCY=2,
// plus LATENCY=1 and LATENCY=15 instances for the latency sweep.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  vld = 3'b000;
    logic [2:0]  rrdy = 3'b000;
    logic        wr = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_if m0 ();
    dmem_if m1 ();
    dmem_if m2 ();

    dmem_responder #(.DEPTH(128), .LATENCY(2))  dut  (.clk_i(clk), .rst_i(rst), .bus(m0));
    dmem_responder #(.DEPTH(128), .LATENCY(1))  dut1 (.clk_i(clk), .rst_i(rst), .bus(m1));
    dmem_responder #(.DEPTH(128), .LATENCY(15)) dut2 (.clk_i(clk), .rst_i(rst), .bus(m2));

    assign m0.req_valid_i = vld[0];
    assign m1.req_valid_i = vld[1];
    assign m2.req_valid_i = vld[2];
    assign m0.rsp_ready_i = rrdy[0];
    assign m1.rsp_ready_i = rrdy[1];
    assign m2.rsp_ready_i = rrdy[2];
    assign m0.req_write_i = wr;
    assign m1.req_write_i = wr;
    assign m2.req_write_i = wr;
    assign m0.req_addr_i  = addr;
    assign m1.req_addr_i  = addr;
    assign m2.req_addr_i  = addr;
    assign m0.req_wdata_i = wdata;
    assign m1.req_wdata_i = wdata;
    assign m2.req_wdata_i = wdata;

    function automatic logic o_valid(int s);
        return (s == 0) ? m0.rsp_valid_o : (s == 1) ? m1.rsp_valid_o : m2.rsp_valid_o;
    endfunction
    function automatic logic [31:0] o_rdata(int s);
        return (s == 0) ? m0.rsp_rdata_o : (s == 1) ? m1.rsp_rdata_o : m2.rsp_rdata_o;
    endfunction
    function automatic logic o_err(int s);
        return (s == 0) ? m0.rsp_err_o : (s == 1) ? m1.rsp_err_o : m2.rsp_err_o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait (bounded) for its response; does not consume it.
    task automatic issue(input int s, input logic w, input logic [31:0] a,
                         input logic [31:0] d, output int lat);
        @(posedge clk); #1;
        wr = w; addr = a; wdata = d;
        vld[s] = 1'b1;
        @(posedge clk); #1;
        vld[s] = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (o_valid(s)) break;
        end
        if (!o_valid(s)) lat = -1;
    endtask

    task automatic consume(input int s);
        rrdy[s] = 1'b1;
        @(posedge clk); #1;
        rrdy[s] = 1'b0;
    endtask

    task automatic access(input int s, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int lat,
                          output logic [31:0] rd, output logic er);
        issue(s, w, a, d, lat);
        rd = o_rdata(s);
        er = o_err(s);
        consume(s);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    logic [31:0] hold_rd;
    logic        hold_er;

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid",  64'(m0.rsp_valid_o), 64'd0);
        chk("rst_rdata",  64'(m0.rsp_rdata_o), 64'd0);
        chk("rst_err",    64'(m0.rsp_err_o), 64'd0);
        chk("rst_errcnt", 64'(m0.err_count_o), 64'd0);
        chk("rst_ready",  64'(m0.req_ready_o), 64'd1);
        chk("rst_busy",   64'(m0.busy_o), 64'd0);

        // Store then load same word
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er);
        chk("st10_lat", 64'(lat), 64'd2);
        chk("st10_rd",  64'(rd), 64'd0);
        chk("st10_err", 64'(er), 64'd0);
        chk("st10_valid_drop", 64'(m0.rsp_valid_o), 64'd0);
        access(0, 1'b0, 32'h10, 32'h0, lat, rd, er);
        chk("ld10_lat", 64'(lat), 64'd2);
        chk("ld10_rd",  64'(rd), 64'hDEADBEEF);
        chk("ld10_err", 64'(er), 64'd0);

        access(0, 1'b1, 32'h4, 32'h11111111, lat, rd, er);
        access(0, 1'b1, 32'h1FC, 32'hCAFEF00D, lat, rd, er);
        chk("st1fc_err", 64'(er), 64'd0);

        // Misaligned load
        access(0, 1'b0, 32'h6, 32'h0, lat, rd, er);
        chk("mis_err", 64'(er), 64'd1);
        chk("mis_rd",  64'(rd), 64'd0);
        chk("mis_cnt", 64'(m0.err_count_o), 64'd1);
        access(0, 1'b0, 32'h4, 32'h0, lat, rd, er);
        chk("ld4_rd",  64'(rd), 64'h11111111);
        chk("ld4_err", 64'(er), 64'd0);

        // Out-of-range store (word index 128)
        access(0, 1'b1, 32'h200, 32'h55555555, lat, rd, er);
        chk("oor_err", 64'(er), 64'd1);
        chk("oor_rd",  64'(rd), 64'd0);
        chk("oor_cnt", 64'(m0.err_count_o), 64'd2);
        access(0, 1'b0, 32'h1FC, 32'h0, lat, rd, er);
        chk("ld1fc_rd", 64'(rd), 64'hCAFEF00D);

        // Hold response with rsp_ready low; a new request must not be taken
        issue(0, 1'b0, 32'h10, 32'h0, lat);
        hold_rd = o_rdata(0);
        hold_er = o_err(0);
        chk("hold_rd0", 64'(hold_rd), 64'hDEADBEEF);
        wr = 1'b1; addr = 32'h20; wdata = 32'h77777777;
        vld[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_stable",
                64'({m0.rsp_valid_o, m0.rsp_rdata_o, m0.rsp_err_o, m0.req_ready_o, m0.busy_o}),
                64'({1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1}));
        end
        rrdy[0] = 1'b1;
        @(posedge clk); #1;
        rrdy[0] = 1'b0;
        vld[0] = 1'b0;
        chk("release_idle",
            64'({m0.rsp_valid_o, m0.req_ready_o, m0.busy_o}), 64'({1'b0, 1'b1, 1'b0}));
        access(0, 1'b0, 32'h20, 32'h0, lat, rd, er);
        chk("held_req_dropped", 64'(rd), 64'd0);

        // Reset on the commit edge of a store
        @(posedge clk); #1;
        wr = 1'b1; addr = 32'h8; wdata = 32'h1234;
        vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstc_valid", 64'(m0.rsp_valid_o), 64'd0);
        chk("rstc_busy",  64'(m0.busy_o), 64'd0);
        chk("rstc_cnt",   64'(m0.err_count_o), 64'd0);
        repeat (3) @(posedge clk);
        #1 chk("rstc_no_rsp", 64'(m0.rsp_valid_o), 64'd0);
        access(0, 1'b0, 32'h8, 32'h0, lat, rd, er);
        chk("rstc_ld8", 64'(rd), 64'd0);

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            access(0, i[0], 32'h1 + 32'(i % 3), 32'h0, lat, rd, er);
            if (i == 253) chk("cnt_254", 64'(m0.err_count_o), 64'd254);
            if (i == 254) chk("cnt_255", 64'(m0.err_count_o), 64'd255);
        end
        chk("cnt_sat", 64'(m0.err_count_o), 64'd255);

        // Latency sweep
        access(1, 1'b1, 32'h40, 32'hA5A5A5A5, lat, rd, er);
        chk("l1_st_lat", 64'(lat), 64'd1);
        access(1, 1'b0, 32'h40, 32'h0, lat, rd, er);
        chk("l1_ld_lat", 64'(lat), 64'd1);
        chk("l1_ld_rd",  64'(rd), 64'hA5A5A5A5);
        access(2, 1'b1, 32'h44, 32'h0BADF00D, lat, rd, er);
        chk("l15_st_lat", 64'(lat), 64'd15);
        access(2, 1'b0, 32'h44, 32'h0, lat, rd, er);
        chk("l15_ld_lat", 64'(lat), 64'd15);
        chk("l15_ld_rd",  64'(rd), 64'h0BADF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
